log_input_packer: RTL and testbench
===================================

# log_input_packer

Write-side counterpart of the SRAM wrapper's configurable-width read path. Accepts narrow writes (32/16/8/4/2/1 bits, selected by `conf`) at logical addresses and places each into its lane of a 32-bit physical row with a per-bit write mask. Consecutive writes to the same row are coalesced in a one-entry buffer and issued as a single masked 32-bit write to the dual-port SRAM macro. It sits between the wrapper's write port and the macro's masked-write interface.

## Interface
- `IDLE_FLUSH`, default 8: idle cycles before a partially filled row is written out; 0 disables the idle flush.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `conf`  in  3  width code: 000=1k×32, 001=2k×16, 010=4k×8, 011=8k×4, 100=16k×2, 101=32k×1. Codes 110 and 111 are treated as 000. Changes only while `busy`=0.
- `in_valid`  in  1  write request.
- `in_ready`  out  1  equals `!O.vld && !flush`.
- `in_addr`  in  15  logical address; bits above 10+conf are ignored.
- `in_data`  in  32  LSB-aligned write data; bits at and above width W are ignored.
- `flush`  in  1  level request: drain the coalesce buffer and block new input.
- `mem_valid`  out  1  masked row write pending.
- `mem_ready`  in  1  macro accepts the write.
- `mem_addr`  out  10  physical row.
- `mem_din`  out  32  row data; bits outside the mask are 0.
- `mem_wmask`  out  32  per-bit write enable.
- `busy`  out  1  `C.vld || O.vld`.

## Operation
- Datapath per request:
  - W = 32>>conf.
  - row = in_addr>>conf, truncated to 10 bits.
  - lane = in_addr[conf-1:0], or 0 when conf=0.
  - m = ((1<<W)-1)<<(lane·W).
  - s = (in_data & ((1<<W)-1))<<(lane·W).
- State is two registers.
  - C (coalesce buffer): vld, row, data, mask.
  - O (output register): drives `mem_valid`/`mem_addr`/`mem_din`/`mem_wmask`.
- Definitions:
  - accept = in_valid && in_ready.
  - hit = C.vld && row==C.row.
  - C.full = (C.mask == 32'hFFFFFFFF).
  - O_avail = !O.vld || mem_ready.
- Rules at each edge, in priority order:
  1. accept && !C.vld: C ← {1, row, s, m}.
  2. accept && hit: C.data ← (C.data & ~m) | s; C.mask ← C.mask | m. The later write wins on overlapping bits.
  3. accept && C.vld && !hit: O ← C; C ← {1, row, s, m}. O is known to be empty because in_ready required it.
  4. !accept && C.vld && O_avail && (C.full || flush || idle_trig): O ← C; C.vld ← 0.
- O clears when `mem_valid && mem_ready` unless rule 4 reloads it on the same edge, which allows back-to-back beats.
- Idle counter:
  - Resets to 0 on accept and whenever C is empty.
  - Otherwise increments, saturating at IDLE_FLUSH.
  - idle_trig = (IDLE_FLUSH != 0) && (count == IDLE_FLUSH).
- `flush` held high drains everything; `busy` falls once the final beat handshakes.
- Reset, including mid-operation: C and O are discarded and no beat is emitted.
- Reset values: `mem_valid`=0; `mem_addr`, `mem_din`, `mem_wmask`=0; `busy`=0; counter=0; `in_ready`=1 when `flush`=0.

## Timing
- `in_ready` is combinational from O.vld and `flush`. There is no path from `mem_ready` or `in_addr` to `in_ready`.
- Request accepted in cycle t:
  - It is in C from t+1.
  - A full row (conf=000, or a row completed by this write) appears on `mem_valid` in t+2.
- Partial row with no further input: `mem_valid` rises in t+2+IDLE_FLUSH.
- Row miss accepted in cycle t: the old row is on `mem_valid` in t+1.
- While `mem_valid && !mem_ready`:
  - `mem_addr`, `mem_din` and `mem_wmask` hold stable.
  - `in_ready`=0.
- Maximum sustained rate:
  - One full row per 2 cycles with `mem_ready` tied high.
  - One narrow write per cycle while hitting the same row.

## Test plan
- conf=000, write addr 5 data 0xDEADBEEF, mem_ready=1 -> one beat two cycles later: addr 5, din 0xDEADBEEF, wmask 0xFFFFFFFF; busy=0 afterwards.
- conf=010, back-to-back writes addr 0x10..0x13 with data 0x11, 0x22, 0x33, 0x44 -> exactly one beat: addr 4, din 0x44332211, wmask 0xFFFFFFFF.
- conf=101, write addr 3 data 1, then addr 40 data 1, IDLE_FLUSH=8 -> beat {addr 0, din 0x8, wmask 0x8} the cycle after the second accept; then {addr 1, din 0x100, wmask 0x100} 10 cycles after the second accept.
- conf=001, IDLE_FLUSH=4, write addr 7 data 0x1234ABCD in cycle t -> mem_valid in t+6 with addr 3, din 0xABCD0000, wmask 0xFFFF0000.
- conf=010, write addr 0 data 0xAA, then addr 0 data 0x55, then flush=1 -> in_ready=0 while flush is high; beat addr 0, din 0x00000055, wmask 0x000000FF.
- Backpressure and reset: hold mem_ready=0 with a beat pending -> outputs stable and in_ready=0 for 10 cycles; then with C also loaded, pull rst_n low mid-stall -> mem_valid=0 and busy=0 immediately, and no beat after rst_n is released.

Source files
------------

// File: rtl/log_input_packer_if.sv
// Request and masked-row-write handshake bundle for log_input_packer.
// The slave modport is the packer's view; master is the surrounding logic.
interface log_input_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_addr;
    logic [31:0] in_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_wmask;

    modport slave (
        input  in_valid, in_addr, in_data, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_din, mem_wmask
    );

    modport master (
        output in_valid, in_addr, in_data, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_din, mem_wmask
    );
endinterface

// File: rtl/log_input_packer.sv
// Packs narrow logical writes into masked 32-bit physical row writes,
// coalescing same-row writes in a one-entry buffer ahead of an output register.
module log_input_packer #(
    parameter int unsigned IDLE_FLUSH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        conf,
    input  logic              flush,
    output logic              busy,
    log_input_packer_if.slave bus
);
    localparam int unsigned   CW       = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_FLUSH);

    logic [2:0]    code;
    logic [31:0]   lane_mask;
    logic [4:0]    lane_idx;
    logic [4:0]    lane_shift;
    logic [9:0]    row;
    logic [31:0]   m;
    logic [31:0]   s;

    logic          c_vld;
    logic [9:0]    c_row;
    logic [31:0]   c_data;
    logic [31:0]   c_mask;
    logic          o_vld;
    logic [9:0]    o_row;
    logic [31:0]   o_data;
    logic [31:0]   o_mask;
    logic [CW-1:0] idle_cnt;

    logic accept, hit, c_full, o_avail, idle_trig;

    // Lane offset is lane*W, and W = 32>>code, so it is lane shifted by 5-code.
    always_comb begin
        code = (conf > 3'd5) ? 3'd0 : conf;
        case (code)
            3'd1:    lane_mask = 32'h0000_FFFF;
            3'd2:    lane_mask = 32'h0000_00FF;
            3'd3:    lane_mask = 32'h0000_000F;
            3'd4:    lane_mask = 32'h0000_0003;
            3'd5:    lane_mask = 32'h0000_0001;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        lane_idx   = 5'(bus.in_addr & ((15'd1 << code) - 15'd1));
        lane_shift = lane_idx << (3'd5 - code);
        row        = 10'(bus.in_addr >> code);
        m          = lane_mask << lane_shift;
        s          = (bus.in_data & lane_mask) << lane_shift;
    end

    assign bus.in_ready  = !o_vld && !flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign hit           = c_vld && (row == c_row);
    assign c_full        = (c_mask == 32'hFFFF_FFFF);
    assign o_avail       = !o_vld || bus.mem_ready;
    assign idle_trig     = (IDLE_FLUSH != 0) && (idle_cnt == IDLE_MAX);

    assign bus.mem_valid = o_vld;
    assign bus.mem_addr  = o_row;
    assign bus.mem_din   = o_data;
    assign bus.mem_wmask = o_mask;
    assign busy          = c_vld || o_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld    <= 1'b0;
            c_row    <= '0;
            c_data   <= '0;
            c_mask   <= '0;
            o_vld    <= 1'b0;
            o_row    <= '0;
            o_data   <= '0;
            o_mask   <= '0;
            idle_cnt <= '0;
        end else begin
            if (accept || !c_vld)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;

            // A completed handshake empties O unless a drain below refills it.
            if (o_vld && bus.mem_ready)
                o_vld <= 1'b0;

            if (accept) begin
                if (hit) begin
                    c_data <= (c_data & ~m) | s;
                    c_mask <= c_mask | m;
                end else begin
                    if (c_vld) begin
                        o_vld  <= 1'b1;
                        o_row  <= c_row;
                        o_data <= c_data;
                        o_mask <= c_mask;
                    end
                    c_vld  <= 1'b1;
                    c_row  <= row;
                    c_data <= s;
                    c_mask <= m;
                end
            end else if (c_vld && o_avail && (c_full || flush || idle_trig)) begin
                o_vld  <= 1'b1;
                o_row  <= c_row;
                o_data <= c_data;
                o_mask <= c_mask;
                c_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_log_input_packer.sv
// Bench for log_input_packer: directed literal scenarios plus randomized traffic
// checked every cycle against a transaction-level model and a row-image compare.
module tb_log_input_packer;
    localparam int unsigned IDLE = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] conf0 = '0;
    logic       flush0 = 1'b0;
    logic       busy0;
    logic [2:0] conf1 = '0;
    logic       flush1 = 1'b0;
    logic       busy1;

    log_input_packer_if bus0 ();
    log_input_packer_if bus1 ();

    log_input_packer #(.IDLE_FLUSH(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .conf(conf0), .flush(flush0), .busy(busy0), .bus(bus0.slave)
    );

    log_input_packer #(.IDLE_FLUSH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .conf(conf1), .flush(flush1), .busy(busy1), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_beats = 0;

    // Model state: coalesce buffer C and output register O as plain values.
    bit          m_cv = 0;
    bit          m_ov = 0;
    logic [9:0]  m_crow = '0, m_orow = '0;
    logic [31:0] m_cdata = '0, m_cmask = '0, m_odata = '0, m_omask = '0;
    int unsigned m_cnt = 0;

    logic [31:0] ref_img [1024];
    logic [31:0] dut_img [1024];
    bit          touched [1024];

    int unsigned md_ce, md_ncnt;
    logic [9:0]  md_r;
    logic [31:0] md_s, md_m;
    bit          md_acc, md_hit, md_oav, md_trig;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lane placement straight from the width rules, bit by bit.
    function automatic void place(input int unsigned ce, input logic [14:0] a, input logic [31:0] d,
                                  output logic [9:0] row, output logic [31:0] s, output logic [31:0] m);
        int unsigned n, w, lane;
        n    = 1 << ce;
        w    = 32 / n;
        lane = int'(a) % n;
        row  = 10'((int'(a) / n) % 1024);
        s    = '0;
        m    = '0;
        for (int unsigned k = 0; k < w; k++) begin
            m[lane*w + k] = 1'b1;
            s[lane*w + k] = d[k];
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cv = 0;
                m_ov = 0;
                m_cnt = 0;
                for (int i = 0; i < 1024; i++) begin
                    ref_img[i] = '0;
                    dut_img[i] = '0;
                    touched[i] = 0;
                end
            end else begin
                if (bus0.mem_valid && bus0.mem_ready) begin
                    n_beats++;
                    dut_img[bus0.mem_addr] = (dut_img[bus0.mem_addr] & ~bus0.mem_wmask)
                                           | (bus0.mem_din & bus0.mem_wmask);
                    touched[bus0.mem_addr] = 1;
                end
                md_ce   = (conf0 > 3'd5) ? 0 : int'(conf0);
                md_acc  = bus0.in_valid && !m_ov && !flush0;
                place(md_ce, bus0.in_addr, bus0.in_data, md_r, md_s, md_m);
                md_hit  = m_cv && (md_r == m_crow);
                md_oav  = !m_ov || bus0.mem_ready;
                md_trig = (IDLE != 0) && (m_cnt == IDLE);
                md_ncnt = (md_acc || !m_cv) ? 0 : ((m_cnt < IDLE) ? m_cnt + 1 : m_cnt);
                if (m_ov && bus0.mem_ready) m_ov = 0;
                if (md_acc) begin
                    ref_img[md_r] = (ref_img[md_r] & ~md_m) | md_s;
                    touched[md_r] = 1;
                    if (md_hit) begin
                        m_cdata = (m_cdata & ~md_m) | md_s;
                        m_cmask = m_cmask | md_m;
                    end else begin
                        if (m_cv) begin
                            m_ov = 1; m_orow = m_crow; m_odata = m_cdata; m_omask = m_cmask;
                        end
                        m_cv = 1; m_crow = md_r; m_cdata = md_s; m_cmask = md_m;
                    end
                end else if (m_cv && md_oav && (m_cmask == 32'hFFFF_FFFF || flush0 || md_trig)) begin
                    m_ov = 1; m_orow = m_crow; m_odata = m_cdata; m_omask = m_cmask;
                    m_cv = 0;
                end
                m_cnt = md_ncnt;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("mem_valid", 32'(bus0.mem_valid), 32'(m_ov));
                if (m_ov) begin
                    check("mem_addr", 32'(bus0.mem_addr), 32'(m_orow));
                    check("mem_din", bus0.mem_din, m_odata);
                    check("mem_wmask", bus0.mem_wmask, m_omask);
                end
                check("in_ready", 32'(bus0.in_ready), 32'(!m_ov && !flush0));
                check("busy", 32'(busy0), 32'(m_cv || m_ov));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [14:0] a, input logic [31:0] d);
        bus0.in_valid = 1'b1;
        bus0.in_addr  = a;
        bus0.in_data  = d;
    endtask

    task automatic check_beat(input string nm, input logic [9:0] a, input logic [31:0] d, input logic [31:0] wm);
        check({nm, "_valid"}, 32'(bus0.mem_valid), 32'd1);
        check({nm, "_addr"}, 32'(bus0.mem_addr), 32'(a));
        check({nm, "_din"}, bus0.mem_din, d);
        check({nm, "_wmask"}, bus0.mem_wmask, wm);
    endtask

    task automatic drain();
        int unsigned k;
        bus0.in_valid  = 1'b0;
        bus0.mem_ready = 1'b1;
        flush0 = 1'b1;
        k = 0;
        step();
        while (busy0 && k < 200) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(busy0), 32'd0);
        flush0 = 1'b0;
        step();
    endtask

    int          b0;
    int unsigned ce_r, row_r, lane_r, base_r, a_r, pv;

    initial begin
        bus0.in_valid = 1'b0; bus0.in_addr = '0; bus0.in_data = '0; bus0.mem_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_addr = '0; bus1.in_data = '0; bus1.mem_ready = 1'b1;

        // Reset state
        #3;
        check("rst_mem_valid", 32'(bus0.mem_valid), 32'd0);
        check("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
        check("rst_mem_din", bus0.mem_din, 32'd0);
        check("rst_mem_wmask", bus0.mem_wmask, 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        step(); step();
        rst_n = 1'b1;
        step();

        // Full 32-bit row: beat two cycles after accept
        conf0 = 3'd0;
        b0 = n_beats;
        step(); wr(15'd5, 32'hDEAD_BEEF);
        step(); bus0.in_valid = 1'b0;
        @(negedge clk); check("t1_early", 32'(bus0.mem_valid), 32'd0);
        step(); @(negedge clk); check_beat("t1", 10'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        step(); @(negedge clk); check("t1_busy", 32'(busy0), 32'd0);
        check("t1_nbeats", 32'(n_beats - b0), 32'd1);

        // Four bytes coalesce into one row
        step(); conf0 = 3'd2;
        b0 = n_beats;
        for (int i = 0; i < 4; i++) begin
            step(); wr(15'(16 + i), 32'((i + 1) * 32'h11));
        end
        step(); bus0.in_valid = 1'b0;
        @(negedge clk); check("t2_early", 32'(bus0.mem_valid), 32'd0);
        step(); @(negedge clk); check_beat("t2", 10'd4, 32'h4433_2211, 32'hFFFF_FFFF);
        repeat (12) step();
        check("t2_nbeats", 32'(n_beats - b0), 32'd1);

        // 1-bit mode: row miss evicts immediately, then idle flush
        step(); conf0 = 3'd5;
        step(); wr(15'd3, 32'd1);
        step(); wr(15'd40, 32'd1);
        step(); bus0.in_valid = 1'b0;
        @(negedge clk);
        check_beat("t3a", 10'd0, 32'h8, 32'h8);
        check("t3a_ready", 32'(bus0.in_ready), 32'd0);
        for (int k = 2; k <= 10; k++) begin
            step(); @(negedge clk);
            if (k < 10) check("t3_gap", 32'(bus0.mem_valid), 32'd0);
            else        check_beat("t3b", 10'd1, 32'h100, 32'h100);
        end

        // 16-bit partial row with IDLE_FLUSH=4 on the second instance
        step(); conf1 = 3'd1;
        step(); bus1.in_valid = 1'b1; bus1.in_addr = 15'd7; bus1.in_data = 32'h1234_ABCD;
        step(); bus1.in_valid = 1'b0;
        repeat (4) begin
            step(); @(negedge clk); check("t4_gap", 32'(bus1.mem_valid), 32'd0);
        end
        step(); @(negedge clk);
        check("t4_valid", 32'(bus1.mem_valid), 32'd1);
        check("t4_addr", 32'(bus1.mem_addr), 32'd3);
        check("t4_din", bus1.mem_din, 32'hABCD_0000);
        check("t4_wmask", bus1.mem_wmask, 32'hFFFF_0000);

        // Overwrite same byte then flush
        step(); conf0 = 3'd2;
        step(); wr(15'd0, 32'hAA);
        step(); wr(15'd0, 32'h55);
        step(); bus0.in_valid = 1'b0; flush0 = 1'b1;
        @(negedge clk); check("t5_ready0", 32'(bus0.in_ready), 32'd0);
        step(); @(negedge clk);
        check_beat("t5", 10'd0, 32'h55, 32'hFF);
        check("t5_ready1", 32'(bus0.in_ready), 32'd0);
        step(); @(negedge clk); check("t5_busy", 32'(busy0), 32'd0);
        step(); flush0 = 1'b0;
        @(negedge clk); check("t5_ready2", 32'(bus0.in_ready), 32'd1);

        // Backpressure with O and C loaded, then reset mid-stall
        step(); conf0 = 3'd2; bus0.mem_ready = 1'b0;
        step(); wr(15'd0, 32'h5A);
        step(); wr(15'd4, 32'h3C);
        step(); wr(15'd8, 32'h77);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_beat("t6_stall", 10'd0, 32'h5A, 32'hFF);
            check("t6_ready", 32'(bus0.in_ready), 32'd0);
            step();
        end
        bus0.in_valid = 1'b0;
        b0 = n_beats;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus0.mem_valid), 32'd0);
        check("t6_rst_busy", 32'(busy0), 32'd0);
        bus0.mem_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk); check("t6_no_beat", 32'(bus0.mem_valid), 32'd0);
            step();
        end
        check("t6_nbeats", 32'(n_beats - b0), 32'd0);

        // Randomized traffic with row locality
        for (int burst = 0; burst < 8; burst++) begin
            drain();
            conf0  = 3'($urandom_range(0, 7));
            ce_r   = (conf0 > 3'd5) ? 0 : int'(conf0);
            base_r = $urandom_range(0, 1023);
            pv     = (burst % 2 == 1) ? 2 : 7;
            for (int c = 0; c < 250; c++) begin
                step();
                row_r  = (base_r + $urandom_range(0, 2)) % 1024;
                lane_r = $urandom_range(0, (1 << ce_r) - 1);
                a_r    = ($urandom << (10 + ce_r)) | (row_r << ce_r) | lane_r;
                bus0.in_valid  = ($urandom_range(0, 9) < pv);
                bus0.in_addr   = 15'(a_r);
                bus0.in_data   = $urandom;
                bus0.mem_ready = ($urandom_range(0, 9) < 8);
                flush0         = ($urandom_range(0, 39) == 0);
            end
        end
        drain();
        for (int i = 0; i < 1024; i++)
            if (touched[i]) check($sformatf("img_row%0d", i), dut_img[i], ref_img[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
